// File: rtl/qspi_io_phy_if.sv
// Controller-side bundle of qspi_io_phy: SCK enable, chip-select request,
// pad drive data, tristate controls and the returned pad data.
`timescale 1ns/1ps
interface qspi_io_phy_if;
  logic       spiclken;
  logic       spiss2;
  logic [3:0] spiout;
  logic       spiz0;
  logic       spiz1;
  logic [3:0] spiin;

  modport master (
    output spiclken, spiss2, spiout, spiz0, spiz1,
    input  spiin
  );

  modport slave (
    input  spiclken, spiss2, spiout, spiz0, spiz1,
    output spiin
  );
endinterface

// File: rtl/qspi_io_phy.sv
// QSPI pad PHY: gated inverted SCK via DDR-style cell, registered chip select,
// quad tristate pads. Define QSPI_IN_REG_EN to register the spiin return path.
`timescale 1ns/1ps
module qspi_io_phy #(
  parameter logic SCK_INIT = 1'b0,
  parameter logic SSN_INIT = 1'b1
) (
  input  logic             spiclk,
  input  logic             reset,
  qspi_io_phy_if.slave     ctrl,
  output logic             spisck,
  output logic             spissn,
  inout  wire  [3:0]       spi_io
);

  logic sck_en_q;
  logic sck_clr;
  logic sck_hi_q;
  logic sck_lo_q;

  always_ff @(posedge spiclk or posedge reset) begin
    if (reset) sck_en_q <= 1'b0;
    else       sck_en_q <= ctrl.spiclken;
  end

  // Clear acts only on the registered enable, so it can only change at a
  // rising edge, where the output already selects the low-phase bit.
  assign sck_clr = reset | ~sck_en_q;

  always_ff @(negedge spiclk or posedge sck_clr) begin
    if (sck_clr) sck_hi_q <= SCK_INIT;
    else         sck_hi_q <= 1'b1;
  end

  always_ff @(posedge spiclk or posedge sck_clr) begin
    if (sck_clr) sck_lo_q <= SCK_INIT;
    else         sck_lo_q <= 1'b0;
  end

  assign spisck = spiclk ? sck_lo_q : sck_hi_q;

  always_ff @(posedge spiclk or posedge reset) begin
    if (reset) spissn <= SSN_INIT;
    else       spissn <= ~ctrl.spiss2;
  end

  assign spi_io[0]   = ctrl.spiz0 ? 1'bz    : ctrl.spiout[0];
  assign spi_io[3:1] = ctrl.spiz1 ? 3'bzzz  : ctrl.spiout[3:1];

`ifdef QSPI_IN_REG_EN
  logic [3:0] spiin_q;

  always_ff @(posedge spiclk or posedge reset) begin
    if (reset) spiin_q <= '0;
    else       spiin_q <= spi_io;
  end

  assign ctrl.spiin = spiin_q;
`else
  assign ctrl.spiin = spi_io;
`endif

endmodule

// File: tb/tb_qspi_io_phy.sv
// Directed self-checking bench for qspi_io_phy (both spiin path variants).
`timescale 1ns/1ps
module tb_qspi_io_phy;

  logic       spiclk;
  logic       reset;
  logic       spisck;
  logic       spissn;
  wire  [3:0] spi_io;
  logic [3:0] ext_drv;
  logic [3:0] ext_en;

  int unsigned checks;
  int unsigned errors;
  int unsigned sck_pulses;
  realtime     sck_rise_t;
  realtime     sck_width;

  qspi_io_phy_if bus();

  qspi_io_phy #(.SCK_INIT(1'b0), .SSN_INIT(1'b1)) dut (
    .spiclk (spiclk),
    .reset  (reset),
    .ctrl   (bus),
    .spisck (spisck),
    .spissn (spissn),
    .spi_io (spi_io)
  );

  for (genvar k = 0; k < 4; k++) begin : g_ext
    assign spi_io[k] = ext_en[k] ? ext_drv[k] : 1'bz;
  end

  initial spiclk = 1'b0;
  always #3.75 spiclk = ~spiclk;

  always @(posedge spisck) begin
    sck_pulses = sck_pulses + 1;
    sck_rise_t = $realtime;
  end
  always @(negedge spisck) sck_width = $realtime - sck_rise_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0; errors = 0; sck_pulses = 0; sck_width = 0; sck_rise_t = 0;
    reset = 1'b1;
    bus.spiclken = 1'b1; bus.spiss2 = 1'b1;
    bus.spiz0 = 1'b0; bus.spiz1 = 1'b0; bus.spiout = 4'h6;
    ext_drv = 4'h0; ext_en = 4'h0;

    // Reset held with enable and chip-select requested
    for (int i = 0; i < 5; i++) begin
      @(posedge spiclk); #1;
      check("rst_sck_hi", {31'd0, spisck}, 32'd0);
      @(negedge spiclk); #1;
      check("rst_sck_lo", {31'd0, spisck}, 32'd0);
      check("rst_ssn", {31'd0, spissn}, 32'd1);
`ifdef QSPI_IN_REG_EN
      check("rst_spiin", {28'd0, bus.spiin}, 32'h0);
`else
      check("rst_spiin", {28'd0, bus.spiin}, 32'h6);
`endif
    end
    check("rst_no_pulses", sck_pulses, 32'd0);

    bus.spiclken = 1'b0; bus.spiss2 = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge spiclk);
    #1;
    check("idle_sck", {31'd0, spisck}, 32'd0);
    check("idle_ssn", {31'd0, spissn}, 32'd1);

    // Clock gating: 8 enabled cycles -> 8 pulses
    sck_pulses = 0;
    bus.spiclken = 1'b1;
    @(negedge spiclk); #1;
    check("gate_first_lo", {31'd0, spisck}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge spiclk); #1;
      if (i == 7) bus.spiclken = 1'b0;
      check("gate_hi_phase", {31'd0, spisck}, 32'd0);
      @(negedge spiclk); #1;
      check("gate_lo_phase", {31'd0, spisck}, 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge spiclk); #1;
      check("gate_after_hi", {31'd0, spisck}, 32'd0);
      @(negedge spiclk); #1;
      check("gate_after_lo", {31'd0, spisck}, 32'd0);
    end
    check("gate_pulses", sck_pulses, 32'd8);
    check("gate_width_ps", int'(sck_width * 1000.0), 32'd3750);

    // Chip select latency
    @(posedge spiclk); #1;
    bus.spiss2 = 1'b1;
    @(negedge spiclk); #1;
    check("cs_pre", {31'd0, spissn}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge spiclk); #1;
      check("cs_low", {31'd0, spissn}, 32'd0);
    end
    bus.spiss2 = 1'b0;
    @(negedge spiclk); #1;
    check("cs_hold", {31'd0, spissn}, 32'd0);
    @(posedge spiclk); #1;
    check("cs_release", {31'd0, spissn}, 32'd1);

    // Command lane: IO0 driven, IO1..3 from external driver
    bus.spiz0 = 1'b0; bus.spiz1 = 1'b1; bus.spiout = 4'b0001;
    ext_drv = 4'b1010; ext_en = 4'b1110;
    @(posedge spiclk); #1;
    check("cmd_io0", {31'd0, spi_io[0]}, 32'd1);
    check("cmd_io_ext", {29'd0, spi_io[3:1]}, 32'b101);
    check("cmd_spiin", {28'd0, bus.spiin}, 32'b1011);

    // Quad read from flash model
    bus.spiz1 = 1'b1; bus.spiz0 = 1'b1; ext_en = 4'hF;
    @(posedge spiclk); #1;
    ext_drv = 4'hA;
`ifndef QSPI_IN_REG_EN
    #1 check("qrd_a", {28'd0, bus.spiin}, 32'hA);
`endif
    @(posedge spiclk); #1;
`ifdef QSPI_IN_REG_EN
    check("qrd_a", {28'd0, bus.spiin}, 32'hA);
`endif
    ext_drv = 4'h5;
`ifndef QSPI_IN_REG_EN
    #1 check("qrd_5", {28'd0, bus.spiin}, 32'h5);
`endif
    @(posedge spiclk); #1;
`ifdef QSPI_IN_REG_EN
    check("qrd_5", {28'd0, bus.spiin}, 32'h5);
`endif

    // Quad address sweep with loopback
    ext_en = 4'h0; bus.spiz0 = 1'b0; bus.spiz1 = 1'b0;
    for (int v = 0; v < 16; v++) begin
      bus.spiout = 4'(v);
      #1;
      check("qad_pad", {28'd0, spi_io}, 32'(v));
`ifdef QSPI_IN_REG_EN
      @(posedge spiclk); #1;
      check("qad_loop", {28'd0, bus.spiin}, 32'(v));
`else
      check("qad_loop", {28'd0, bus.spiin}, 32'(v));
      @(posedge spiclk); #1;
`endif
    end

    // Reset mid-transfer, asserted during SCK high
    bus.spiclken = 1'b1; bus.spiss2 = 1'b1; bus.spiout = 4'h9;
    repeat (3) @(posedge spiclk);
    @(negedge spiclk); #1;
    check("mid_sck_high", {31'd0, spisck}, 32'd1);
    check("mid_ssn_low", {31'd0, spissn}, 32'd0);
    reset = 1'b1;
    #0.5;
    check("mid_rst_sck", {31'd0, spisck}, 32'd0);
    check("mid_rst_ssn", {31'd0, spissn}, 32'd1);
    check("mid_rst_pad", {28'd0, spi_io}, 32'h9);
    @(negedge spiclk); #1;
    check("mid_rst_dominate", {31'd0, spisck}, 32'd0);
    bus.spiclken = 1'b0; bus.spiss2 = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge spiclk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
